// File: rtl/elastic_async_operator_pkg.sv
// Shared op encoding and decode helpers for the elastic dataflow operator node.
// op_decode maps the OP string parameter to an encoding; OP_BAD flags unknown names.
package elastic_async_operator_pkg;

  localparam int OP_REG  = 0;
  localparam int OP_IN   = 1;
  localparam int OP_OUT  = 2;
  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_MUL  = 5;
  localparam int OP_ADDI = 6;
  localparam int OP_SUBI = 7;
  localparam int OP_MULI = 8;
  localparam int OP_MIN  = 9;
  localparam int OP_MAX  = 10;
  localparam int OP_BAD  = 15;

  function automatic int op_decode(input string s);
    if (s == "reg")  return OP_REG;
    if (s == "in")   return OP_IN;
    if (s == "out")  return OP_OUT;
    if (s == "add")  return OP_ADD;
    if (s == "sub")  return OP_SUB;
    if (s == "mul")  return OP_MUL;
    if (s == "addi") return OP_ADDI;
    if (s == "subi") return OP_SUBI;
    if (s == "muli") return OP_MULI;
    if (s == "min")  return OP_MIN;
    if (s == "max")  return OP_MAX;
    return OP_BAD;
  endfunction

  // Pass-through and immediate ops are only defined for a single operand.
  function automatic bit op_single_input(input int op);
    return (op == OP_REG) || (op == OP_IN) || (op == OP_OUT) ||
           (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MULI);
  endfunction

endpackage

// File: rtl/elastic_async_operator_handshake_fifo.sv
// Synchronous first-word-fall-through FIFO of DEPTH entries (power of two).
// A push while full is accepted only when a pop happens on the same edge.
module handshake_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             do_push, do_pop;

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == (AW+1)'(DEPTH));
  assign occupancy = occ_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      occ_d = occ_q + 1'b1;
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/elastic_async_operator.sv
// Dataflow operator node: buffers INPUT_SIZE req/ack token streams, fires one op when all
// heads are present, then hands the registered result to OUTPUT_SIZE consumers independently.
module elastic_async_operator
  import elastic_async_operator_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INPUT_SIZE  = 2,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 4,
  parameter string                 OP          = "add",
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [31:0]                      count,
  output logic                             overflow
);

  localparam int OPC   = op_decode(OP);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam bit CFG_OK = (OPC != OP_BAD) &&
                          (INPUT_SIZE >= 1) && (INPUT_SIZE <= 4) &&
                          (OUTPUT_SIZE >= 1) && (OUTPUT_SIZE <= 8) &&
                          (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
                          (!op_single_input(OPC) || (INPUT_SIZE == 1));

  if (!CFG_OK) begin : g_bad_cfg
    $fatal(1, "elastic_async_operator: illegal OP/INPUT_SIZE/OUTPUT_SIZE/DEPTH combination");
  end

  logic [INPUT_SIZE-1:0]  req_l_q, req_l_d;
  logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
  logic [OUTPUT_SIZE-1:0] pending_q, pending_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic [31:0]            count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [INPUT_SIZE-1:0]  push, full, empty;
  logic [DATA_WIDTH-1:0]  head [INPUT_SIZE];
  logic [OCC_W-1:0]       occ  [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  result;
  logic                   fire;

  for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_in
    handshake_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[gi]),
      .pop       (fire),
      .wdata     (din[DATA_WIDTH*gi +: DATA_WIDTH]),
      .rdata     (head[gi]),
      .empty     (empty[gi]),
      .full      (full[gi]),
      .occupancy (occ[gi])
    );
  end

  // ack_r==0 keeps a new fire from overlapping the final consumer ack of the previous result.
  assign fire = (empty == '0) && (pending_q == '0) && (ack_r_q == '0);

  always_comb begin
    push       = '0;
    req_l_d    = '0;
    overflow_d = overflow_q;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      push[i] = ack_l[i] && (!full[i] || fire);
      if (ack_l[i] && full[i] && !fire) overflow_d = 1'b1;
      // Re-request only while one more token still fits after the in-flight ack lands.
      req_l_d[i] = !ack_l[i] && ((int'(occ[i]) - int'(fire)) <= DEPTH - 2);
    end
  end

  always_comb begin
    result = head[0];
    case (OPC)
      OP_ADD:  for (int i = 1; i < INPUT_SIZE; i++) result = result + head[i];
      OP_SUB:  for (int i = 1; i < INPUT_SIZE; i++) result = result - head[i];
      OP_MUL:  for (int i = 1; i < INPUT_SIZE; i++) result = result * head[i];
      OP_ADDI: result = head[0] + IMMEDIATE;
      OP_SUBI: result = head[0] - IMMEDIATE;
      OP_MULI: result = head[0] * IMMEDIATE;
      OP_MIN:  for (int i = 1; i < INPUT_SIZE; i++) if (head[i] < result) result = head[i];
      OP_MAX:  for (int i = 1; i < INPUT_SIZE; i++) if (head[i] > result) result = head[i];
      default: result = head[0];
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    ack_r_d   = '0;
    dout_d    = dout_q;
    count_d   = count_q;
    if (fire) begin
      pending_d = '1;
      dout_d    = result;
      count_d   = count_q + 32'd1;
    end
    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      if (pending_q[j] && req_r[j] && !ack_r_q[j]) begin
        ack_r_d[j]   = 1'b1;
        pending_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_l_q    <= '0;
      ack_r_q    <= '0;
      pending_q  <= '0;
      dout_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      req_l_q    <= req_l_d;
      ack_r_q    <= ack_r_d;
      pending_q  <= pending_d;
      dout_q     <= dout_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign req_l    = req_l_q;
  assign ack_r    = ack_r_q;
  assign dout     = dout_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: doc/elastic_async_operator.md
Name: elastic_async_operator

Overview:
- Parametrised successor of the dataflow operator node used in the generated `arf` graphs.
- Consumes tokens from INPUT_SIZE upstream producers through the req/ack pull handshake and applies one arithmetic op.
- Sends each result to OUTPUT_SIZE downstream consumers.
- New relative to the previous node:
  - per-input FIFO buffering of DEPTH tokens, fully synchronous capture (no ack-edge clocking);
  - independent per-consumer acknowledge instead of an all-consumers-at-once rendezvous;
  - extended op set and a fired-token counter.

Parameters:
- DATA_WIDTH, 32, token width in bits.
- INPUT_SIZE, 2, number of operand inputs, legal range 1..4.
- OUTPUT_SIZE, 1, number of consumers, legal range 1..8.
- DEPTH, 4, per-input FIFO depth; power of two, at least 2.
- OP, "add", one of reg/in/out/add/sub/mul/addi/subi/muli/min/max.
- IMMEDIATE, 0, constant operand for the *i ops.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  active-low asynchronous reset.
- req_l  out  INPUT_SIZE  per-input request to upstream producer.
- ack_l  in  INPUT_SIZE  per-input one-cycle ack from producer; data valid on din in the same cycle.
- din  in  DATA_WIDTH*INPUT_SIZE  operand i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- req_r  in  OUTPUT_SIZE  per-consumer request.
- ack_r  out  OUTPUT_SIZE  per-consumer one-cycle ack; dout valid while high.
- dout  out  DATA_WIDTH  result register.
- count  out  32  number of results fired; wraps modulo 2^32.
- overflow  out  1  sticky error flag: ack_l arrived for a full FIFO.

Behaviour:
- Reset (rst low, asynchronous):
  - req_l=0, ack_r=0, dout=0, count=0, overflow=0;
  - all FIFOs empty, all pending bits 0.
  - Reset mid-operation discards all buffered and pending tokens, with no partial ack.
- Input side, per input i, all signals registered:
  - An edge that samples ack_l[i]=1 writes din slice i into FIFO i and forces req_l[i]<=0 for that cycle.
  - Otherwise req_l[i]<=1 iff occupancy after this edge is <= DEPTH-2.
  - This bounds in-flight acks to one, so the FIFO never overflows against a compliant producer.
  - If ack_l[i]=1 while FIFO i is full, the write is dropped and overflow is set (sticky until reset).
- Fire condition: all FIFOs non-empty AND pending==0 AND ack_r==0. On the firing edge:
  - pop one entry from every FIFO;
  - dout <= op(heads);
  - pending <= all ones;
  - count <= count+1.
- Output side, per consumer j:
  - If pending[j] && req_r[j] && !ack_r[j], then ack_r[j]<=1 for exactly one cycle and pending[j]<=0.
  - Consumers ack independently and in any order.
  - dout is stable from fire until the cycle after the last ack_r drops.
- Latency and throughput:
  - Minimum latency: ack_l sampled at edge t → fire at t+1 → ack_r high after t+2.
  - With steady requests, peak throughput is 1 result per 3 cycles.
- Arithmetic:
  - All ops are unsigned and truncated to DATA_WIDTH, i.e. modulo 2^DATA_WIDTH.
  - sub is operand0-operand1-...; mul is the product of all operands; min and max are unsigned.
  - *i ops and reg/in/out require INPUT_SIZE=1; reg/in/out pass the operand through.
  - An illegal OP/INPUT_SIZE combination is a fatal elaboration error.
- Simultaneous events:
  - FIFO push and pop on the same edge leave occupancy unchanged.
  - A full FIFO may accept a push on the same edge it is popped.
  - Fire and the last ack_r never coincide, which the ack_r==0 term in the fire condition guarantees.

Decomposition:
- Shared package: op encoding constants (OP_REG..OP_MAX) and a string-to-op decode function.
- Sub-module `handshake_fifo` (synchronous, DEPTH entries):
  - ports: push, pop, wdata, rdata head (first-word-fall-through), empty, full, occupancy;
  - instantiated INPUT_SIZE times via generate.
- Operand combine logic lives in the top module, as an always block over the generate-collected heads.

Test Plan:
- INPUT_SIZE=2, OP=add, producers supply 3,4,5.. and 10,20,30.. → consumer receives 13, 24, 35...; count=3 after three acks; first ack_r exactly 2 edges after both ack_l sampled.
- OUTPUT_SIZE=3, consumer 1 holds req_r low for 10 cycles → ack_r[0] and ack_r[2] fire at once; ack_r[1] fires after req_r[1] rises; no second fire until then; dout unchanged throughout.
- DEPTH=4, consumer stalled, producer always ready → each FIFO fills to 3, and req_l stays 0 at occupancy 3; releasing the consumer drains tokens in order with overflow=0.
- Forced ack_l pulses on a full FIFO → overflow=1 and stays 1; FIFO contents unchanged.
- OP=subi, IMMEDIATE=2, input 1 → dout=0xFFFFFFFF. OP=max with operands 7 and 0x80000000 → 0x80000000.
- Assert rst low mid-stream with pending bits set → outputs zero asynchronously; after release the first result is computed from fresh tokens only.
